// File: rtl/hold_study_pkg.sv
`default_nettype none
// ============================================================================
// Package  : hold_study_pkg
// Brief    : Shared state encoding, default timing constants and counter
//            width helper for the hold-time stimulus generator.
// Revision : 1.0
// ============================================================================
package hold_study_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RST_DUT = 3'd1,
        SETUP   = 3'd2,
        EDGE    = 3'd3,
        SAMPLE  = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam int c_DEF_SKEW_MAX     = 63;
    localparam int c_DEF_SETUP_TICKS  = 8;
    localparam int c_DEF_SETTLE_TICKS = 80;

    function automatic int cnt_width(input int settle_ticks);
        return $clog2(settle_ticks + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hold_study_trial_timer.sv
`default_nettype none
// ============================================================================
// Module   : hold_study_trial_timer
// Brief    : Loadable up/down phase counter; direction is latched on load and
//            the counter parks once its terminal value is reached.
// Revision : 1.0
// ============================================================================
module hold_study_trial_timer
    import hold_study_pkg::*;
#(
    parameter int CNT_W = cnt_width(c_DEF_SETTLE_TICKS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_load_up,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic [CNT_W-1:0] i_limit,
    output logic [CNT_W-1:0] o_count,
    output logic             o_term
);

    logic [CNT_W-1:0] r_count;
    logic             r_up;
    logic             w_term;

    // Up mode ends at i_limit, down mode ends at zero.
    assign w_term = r_up ? (r_count == i_limit) : (r_count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_up    <= 1'b0;
        end else if (i_load) begin
            r_count <= i_load_val;
            r_up    <= i_load_up;
        end else if (!w_term) begin
            r_count <= r_up ? (r_count + CNT_W'(1)) : (r_count - CNT_W'(1));
        end
    end

    assign o_count = r_count;
    assign o_term  = w_term;

endmodule
`default_nettype wire

// File: rtl/hold_study_stim_gen.sv
`default_nettype none
// ============================================================================
// Module   : hold_study_stim_gen
// Brief    : Drives clock/data of a flop under test, sweeping the data hold
//            skew downward and reporting the minimum passing hold skew.
// Revision : 1.0
// ============================================================================
module hold_study_stim_gen
    import hold_study_pkg::*;
#(
    parameter int SKEW_MAX     = c_DEF_SKEW_MAX,
    parameter int SETUP_TICKS  = c_DEF_SETUP_TICKS,
    parameter int SETTLE_TICKS = c_DEF_SETTLE_TICKS,
    parameter int CNT_W        = cnt_width(SETTLE_TICKS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             q_dut,
    output logic             clk_dut,
    output logic             d_dut,
    output logic             rst_dut_n,
    output logic             busy,
    output logic             fin_test,
    output logic [CNT_W-1:0] hold_ticks,
    output logic             hold_valid,
    output logic [CNT_W-1:0] trial_skew
);

    if (SETTLE_TICKS <= SKEW_MAX) begin : g_chk_settle
        $error("hold_study_stim_gen: SETTLE_TICKS must exceed SKEW_MAX");
    end

    if (SETUP_TICKS < 1 || SETUP_TICKS > SETTLE_TICKS) begin : g_chk_setup
        $error("hold_study_stim_gen: SETUP_TICKS must lie in 1..SETTLE_TICKS");
    end

    localparam logic [CNT_W-1:0] c_SKEW_MAX    = CNT_W'(SKEW_MAX);
    localparam logic [CNT_W-1:0] c_SETUP_LOAD  = CNT_W'(SETUP_TICKS - 1);
    localparam logic [CNT_W-1:0] c_SETTLE_LAST = CNT_W'(SETTLE_TICKS - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_skew;
    logic [CNT_W-1:0] r_hold_ticks;
    logic             r_hold_valid;
    logic             r_fin;
    logic             r_busy;
    logic             r_clk_dut;
    logic             r_d_dut;
    logic             r_rst_dut_n;

    logic             w_load;
    logic             w_load_up;
    logic [CNT_W-1:0] w_load_val;
    logic [CNT_W-1:0] w_count;
    logic             w_term;
    logic [CNT_W:0]   w_edge_next;

    // SETUP counts down from SETUP_TICKS-1; EDGE counts up from 0.
    assign w_load      = (r_state == RST_DUT) || ((r_state == SETUP) && w_term);
    assign w_load_up   = (r_state == SETUP);
    assign w_load_val  = (r_state == SETUP) ? '0 : c_SETUP_LOAD;
    assign w_edge_next = {1'b0, w_count} + (CNT_W+1)'(1);

    hold_study_trial_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_up  (w_load_up),
        .i_load_val (w_load_val),
        .i_limit    (c_SETTLE_LAST),
        .o_count    (w_count),
        .o_term     (w_term)
    );

    // Outputs are registered alongside the state, so each reflects the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_skew       <= '0;
            r_hold_ticks <= '0;
            r_hold_valid <= 1'b0;
            r_fin        <= 1'b0;
            r_busy       <= 1'b0;
            r_clk_dut    <= 1'b0;
            r_d_dut      <= 1'b0;
            r_rst_dut_n  <= 1'b1;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state      <= RST_DUT;
                        r_skew       <= c_SKEW_MAX;
                        r_hold_ticks <= '0;
                        r_hold_valid <= 1'b0;
                        r_fin        <= 1'b0;
                        r_busy       <= 1'b1;
                        r_rst_dut_n  <= 1'b0;
                        r_clk_dut    <= 1'b0;
                        r_d_dut      <= 1'b0;
                    end
                end
                RST_DUT: begin
                    r_state     <= SETUP;
                    r_rst_dut_n <= 1'b1;
                    r_d_dut     <= 1'b1;
                end
                SETUP: begin
                    if (w_term) begin
                        r_state   <= EDGE;
                        r_clk_dut <= 1'b1;
                        r_d_dut   <= (r_skew != '0);
                    end
                end
                EDGE: begin
                    if (w_term) begin
                        r_state   <= SAMPLE;
                        r_clk_dut <= 1'b0;
                        r_d_dut   <= 1'b0;
                    end else begin
                        r_d_dut <= (w_edge_next < {1'b0, r_skew});
                    end
                end
                SAMPLE: begin
                    if (q_dut && (r_skew != '0)) begin
                        r_skew      <= r_skew - CNT_W'(1);
                        r_state     <= RST_DUT;
                        r_rst_dut_n <= 1'b0;
                    end else begin
                        r_state <= DONE;
                        r_fin   <= 1'b1;
                        r_busy  <= 1'b0;
                        if (q_dut) begin
                            r_hold_ticks <= '0;
                            r_hold_valid <= 1'b1;
                        end else if (r_skew == c_SKEW_MAX) begin
                            r_hold_ticks <= c_SKEW_MAX;
                            r_hold_valid <= 1'b0;
                        end else begin
                            r_hold_ticks <= r_skew + CNT_W'(1);
                            r_hold_valid <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign clk_dut    = r_clk_dut;
    assign d_dut      = r_d_dut;
    assign rst_dut_n  = r_rst_dut_n;
    assign busy       = r_busy;
    assign fin_test   = r_fin;
    assign hold_ticks = r_hold_ticks;
    assign hold_valid = r_hold_valid;
    assign trial_skew = r_skew;

endmodule
`default_nettype wire

// File: tb/tb_hold_study_stim_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_hold_study_stim_gen
// Brief    : Self-checking bench: flop-under-test model with a programmable
//            hold requirement, per-cycle sweep-plan model and directed tests.
// Revision : 1.0
// ============================================================================
module tb_hold_study_stim_gen;

    localparam int SKEW_MAX = 63;
    localparam int SETUP    = 8;
    localparam int SETTLE   = 80;
    localparam int CNT_W    = 7;
    localparam int TRIAL    = 1 + SETUP + SETTLE + 1;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic             q_dut = 1'b0;
    logic             clk_dut, d_dut, rst_dut_n, busy, fin_test, hold_valid;
    logic [CNT_W-1:0] hold_ticks, trial_skew;

    int n_tests = 0;
    int n_fail  = 0;
    int h_req   = 5;

    // waveform statistics gathered by the flop model
    int gap_of [0:63];
    int rst_runs, rst_min, rst_max, rst_len;

    // sweep-plan model state
    bit m_busy, m_fin, m_valid;
    int m_n, m_T, m_hold, m_last_skew;

    always #5 clk = ~clk;

    hold_study_stim_gen #(
        .SKEW_MAX     (SKEW_MAX),
        .SETUP_TICKS  (SETUP),
        .SETTLE_TICKS (SETTLE),
        .CNT_W        (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .q_dut      (q_dut),
        .clk_dut    (clk_dut),
        .d_dut      (d_dut),
        .rst_dut_n  (rst_dut_n),
        .busy       (busy),
        .fin_test   (fin_test),
        .hold_ticks (hold_ticks),
        .hold_valid (hold_valid),
        .trial_skew (trial_skew)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic int trials_for(input int h);
        if (h > SKEW_MAX) return 1;
        if (h == 0)       return SKEW_MAX + 1;
        return SKEW_MAX + 2 - h;
    endfunction

    // Flop under test: captures D=1 only if D stays high at least h_req cycles
    // after the clock rise; shows the captured value in the cycle after the clock
    // falls and a toggling glitch pattern at every other time.
    initial begin
        bit prev_clk;
        bit counting;
        int hi_cnt;
        prev_clk = 1'b0;
        counting = 1'b0;
        hi_cnt   = 0;
        forever begin
            @(negedge clk);
            if (clk_dut && !prev_clk) begin
                hi_cnt   = d_dut ? 1 : 0;
                counting = d_dut;
            end else if (clk_dut && counting) begin
                if (d_dut) hi_cnt++;
                else       counting = 1'b0;
            end
            if (!clk_dut && prev_clk) begin
                q_dut = (hi_cnt >= h_req);
                if (int'(trial_skew) < 64) gap_of[int'(trial_skew)] = hi_cnt;
            end else begin
                q_dut = ~q_dut;
            end
            if (!rst_dut_n) begin
                rst_len++;
            end else if (rst_len != 0) begin
                rst_runs++;
                if (rst_len < rst_min) rst_min = rst_len;
                if (rst_len > rst_max) rst_max = rst_len;
                rst_len = 0;
            end
            prev_clk = clk_dut;
        end
    end

    // Sweep-plan model: a sweep is a known number of fixed-length trials.
    initial begin
        m_busy = 0; m_fin = 0; m_valid = 0; m_n = 0; m_T = 0; m_hold = 0; m_last_skew = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_busy = 0; m_fin = 0; m_valid = 0; m_n = 0; m_hold = 0; m_last_skew = 0;
            end else if (!m_busy) begin
                if (start) begin
                    m_busy = 1; m_fin = 0; m_valid = 0; m_hold = 0; m_n = 0;
                    m_T = trials_for(h_req);
                end
            end else begin
                m_n++;
                if (m_n == m_T * TRIAL) begin
                    m_busy      = 0;
                    m_fin       = 1;
                    m_hold      = (h_req > SKEW_MAX) ? SKEW_MAX : h_req;
                    m_valid     = (h_req <= SKEW_MAX);
                    m_last_skew = SKEW_MAX - (m_T - 1);
                end
            end
        end
    end

    task automatic compare_cycle();
        bit e_clk, e_d, e_rst;
        int e_skew, p;
        if (m_busy) begin
            p      = m_n % TRIAL;
            e_skew = SKEW_MAX - m_n / TRIAL;
            e_rst  = (p != 0);
            e_clk  = (p >= 1 + SETUP) && (p < 1 + SETUP + SETTLE);
            e_d    = (p >= 1 && p <= SETUP) || (e_clk && (p - 1 - SETUP) < e_skew);
        end else begin
            e_skew = m_last_skew;
            e_rst  = 1'b1;
            e_clk  = 1'b0;
            e_d    = 1'b0;
        end
        n_tests++;
        if (busy !== m_busy || fin_test !== m_fin || hold_valid !== m_valid ||
            int'(hold_ticks) != m_hold || int'(trial_skew) != e_skew ||
            clk_dut !== e_clk || d_dut !== e_d || rst_dut_n !== e_rst) begin
            n_fail++;
            $display("FAIL cycle t=%0t: got busy=%b fin=%b valid=%b hold=%0d skew=%0d clk=%b d=%b rstn=%b, want busy=%b fin=%b valid=%b hold=%0d skew=%0d clk=%b d=%b rstn=%b",
                     $time, busy, fin_test, hold_valid, hold_ticks, trial_skew, clk_dut, d_dut, rst_dut_n,
                     m_busy, m_fin, m_valid, m_hold, e_skew, e_clk, e_d, e_rst);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            compare_cycle();
        end
    end

    task automatic run_sweep(input int h, input bit hold_start, input int exp_cyc,
                             input int exp_hold, input bit exp_valid, input string tag);
        int cyc;
        h_req = h;
        start = 1'b1;
        cyc   = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
            if (!hold_start) start = 1'b0;
        end while (!fin_test && cyc < 20000);
        check({tag, "_cycles"}, cyc, exp_cyc);
        check({tag, "_hold_ticks"}, int'(hold_ticks), exp_hold);
        check({tag, "_hold_valid"}, int'(hold_valid), int'(exp_valid));
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_fin"}, int'(fin_test), 0);
        check({tag, "_hold"}, int'(hold_ticks) + 100 * int'(hold_valid), 0);
        check({tag, "_skew"}, int'(trial_skew), 0);
        check({tag, "_pins"}, {29'd0, clk_dut, d_dut, rst_dut_n}, 1);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check_reset_values("reset");

        run_sweep(5, 1'b0, 1 + 60 * TRIAL, 5, 1'b1, "nominal");

        for (int i = 0; i < 64; i++) gap_of[i] = -1;
        rst_runs = 0; rst_min = 1000; rst_max = 0;
        run_sweep(0, 1'b0, 1 + 64 * TRIAL, 0, 1'b1, "zero_hold");
        check("gap_skew3", gap_of[3], 3);
        check("gap_skew0", gap_of[0], 0);
        check("rst_dut_runs", rst_runs, 64);
        check("rst_dut_min_len", rst_min, 1);
        check("rst_dut_max_len", rst_max, 1);

        run_sweep(70, 1'b0, 1 + TRIAL, 63, 1'b0, "out_of_range");
        check("out_of_range_fin", int'(fin_test), 1);

        run_sweep(60, 1'b1, 1 + 5 * TRIAL, 60, 1'b1, "held");
        @(posedge clk); #1;
        check("held_restart_fin", int'(fin_test), 0);
        check("held_restart_busy", int'(busy), 1);
        check("held_restart_hold_clr", int'(hold_ticks), 0);
        run_sweep(60, 1'b1, 5 * TRIAL, 60, 1'b1, "held_again");
        start = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("held_idle_fin", int'(fin_test), 1);

        h_req = 5;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9 * TRIAL + 1 + SETUP + 20) @(posedge clk);
        #1;
        check("mid_edge_clk", int'(clk_dut), 1);
        check("mid_edge_skew", int'(trial_skew), SKEW_MAX - 9);
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_sweep(5, 1'b0, 1 + 60 * TRIAL, 5, 1'b1, "fresh");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
